snoop_bus_arbiter: RTL and testbench

Sequences ownership of the shared coherence snoop bus among NUM_CPUS cache controllers. Picks one requester per bus transaction using a priority-class round-robin scheme: starved requesters first, then writebacks, then everything else. Holds the grant from issue until the bus signals completion. Sits between the per-CPU cache controllers and the snoop bus datapath, and replaces the bus's internal first-found arbitration with aging, priority and timeout supervision.

---
 rtl/coh_pkg.sv | 24 ++
 rtl/rr_pick.sv | 29 ++
 rtl/snoop_bus_arbiter.sv | 168 ++++++++++++++++
 tb/tb_snoop_bus_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/coh_pkg.sv
// coh_pkg: shared op encodings, arbiter state enum and index-width helper for the snoop bus arbiter.
package coh_pkg;

    typedef enum logic [2:0] {
        OP_WB  = 3'b000,
        OP_RD  = 3'b001,
        OP_RDX = 3'b010,
        OP_UPG = 3'b011
    } coh_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_BUSY,
        ST_RELEASE
    } arb_state_e;

    localparam int LOCK_MAX = 4;

    function automatic int CPU_IDX_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: masked round-robin picker; first set request at or above ptr_i, wrapping.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    always_comb begin
        int j;
        gnt_o = '0;
        idx_o = '0;
        any_o = |req_i;
        // scan farthest offset first so the nearest request overwrites last
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr_i) + k;
            j = (j >= N) ? j - N : j;
            if (req_i[j]) begin
                gnt_o = {{(N-1){1'b0}}, 1'b1} << j;
                idx_o = W'(j);
            end
        end
    end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// snoop_bus_arbiter: aging/priority round-robin owner of the coherence snoop bus with watchdog.
// Define SNOOP_ARB_LOCK_EN to add the lock input for back-to-back atomic transactions.
module snoop_bus_arbiter
    import coh_pkg::*;
#(
    parameter int NUM_CPUS     = 4,
    parameter int STARVE_LIMIT = 16,
    parameter int TIMEOUT      = 255,
    parameter int AGE_W        = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_CPUS-1:0]              req,
    input  logic [NUM_CPUS*3-1:0]            req_op,
    output logic [NUM_CPUS-1:0]              grant,
    output logic [CPU_IDX_W(NUM_CPUS)-1:0]   grant_id,
    output logic                             issue_valid,
    output logic [2:0]                       issue_op,
    input  logic                             issue_ready,
    input  logic                             txn_done,
`ifdef SNOOP_ARB_LOCK_EN
    input  logic                             lock,
`endif
    output logic                             busy,
    output logic [NUM_CPUS-1:0]              starved,
    output logic                             err_timeout
);

    localparam int IW   = CPU_IDX_W(NUM_CPUS);
    localparam int WD_W = $clog2(TIMEOUT + 2);

    arb_state_e          state_q, state_d;
    logic [IW-1:0]       owner_q, owner_d;
    logic [NUM_CPUS-1:0] grant_q, grant_d;
    logic [2:0]          issue_op_q, issue_op_d;
    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
    logic                err_q, err_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic [AGE_W-1:0]    age_q [NUM_CPUS];
    logic [AGE_W-1:0]    age_d [NUM_CPUS];
    logic [NUM_CPUS-1:0] starved_q, starved_d;

    logic [NUM_CPUS-1:0] urg_req, wb_req, urg_gnt, wb_gnt, any_gnt, win_gnt;
    logic [IW-1:0]       urg_idx, wb_idx, any_idx, win_idx;
    logic                urg_any, wb_any, req_any;
    logic                wd_expire, relock;

    assign urg_req = req & starved_q;

    always_comb begin
        for (int i = 0; i < NUM_CPUS; i++)
            wb_req[i] = req[i] && (req_op[3*i +: 3] == OP_WB);
    end

    rr_pick #(.N(NUM_CPUS), .W(IW)) u_pick_urg (
        .req_i (urg_req), .ptr_i (rr_ptr_q), .gnt_o (urg_gnt), .idx_o (urg_idx), .any_o (urg_any)
    );

    rr_pick #(.N(NUM_CPUS), .W(IW)) u_pick_wb (
        .req_i (wb_req), .ptr_i (rr_ptr_q), .gnt_o (wb_gnt), .idx_o (wb_idx), .any_o (wb_any)
    );

    rr_pick #(.N(NUM_CPUS), .W(IW)) u_pick_any (
        .req_i (req), .ptr_i (rr_ptr_q), .gnt_o (any_gnt), .idx_o (any_idx), .any_o (req_any)
    );

    // only the highest non-empty class takes part in the decision
    assign win_gnt = urg_any ? urg_gnt : wb_any ? wb_gnt : any_gnt;
    assign win_idx = urg_any ? urg_idx : wb_any ? wb_idx : any_idx;

    assign wd_expire = (TIMEOUT != 0) && (wd_q == WD_W'(TIMEOUT - 1));

`ifdef SNOOP_ARB_LOCK_EN
    logic [2:0] lock_cnt_q, lock_cnt_d;

    assign relock = lock && req[owner_q] && (lock_cnt_q < 3'(LOCK_MAX));

    always_comb
        lock_cnt_d = (state_q == ST_RELEASE) ? '0 :
                     (state_q == ST_BUSY && txn_done && relock) ? lock_cnt_q + 1'b1 : lock_cnt_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) lock_cnt_q <= '0;
        else        lock_cnt_q <= lock_cnt_d;
`else
    assign relock = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (req_any) state_d = ST_ISSUE;
            ST_ISSUE:   state_d = issue_ready ? ST_BUSY : !req[owner_q] ? ST_RELEASE : ST_ISSUE;
            ST_BUSY:    state_d = txn_done ? (relock ? ST_ISSUE : ST_RELEASE) :
                                  wd_expire ? ST_RELEASE : ST_BUSY;
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        issue_valid = (state_q == ST_ISSUE);
        busy        = (state_q != ST_IDLE);
    end

    always_comb begin
        owner_d    = owner_q;
        grant_d    = grant_q;
        issue_op_d = issue_op_q;
        rr_ptr_d   = rr_ptr_q;
        err_d      = err_q;
        wd_d       = wd_q;
        if (state_q == ST_IDLE && req_any) begin
            owner_d    = win_idx;
            grant_d    = win_gnt;
            issue_op_d = req_op[3*win_idx +: 3];
        end
        if (state_q == ST_ISSUE && issue_ready) wd_d = '0;
        if (state_q == ST_BUSY) wd_d = wd_q + 1'b1;
        if (state_q == ST_BUSY && !txn_done && wd_expire) err_d = 1'b1;
        if (state_q == ST_BUSY && txn_done && relock) issue_op_d = req_op[3*owner_q +: 3];
        if (state_q == ST_RELEASE) begin
            grant_d  = '0;
            rr_ptr_d = (owner_q == IW'(NUM_CPUS - 1)) ? '0 : owner_q + 1'b1;
        end
    end

    // the owner (or the CPU being selected this cycle) does not age
    always_comb begin
        for (int i = 0; i < NUM_CPUS; i++) begin
            age_d[i] = (!req[i] || ((state_q == ST_IDLE) ? win_gnt[i] : grant_q[i])) ? '0 :
                       (&age_q[i]) ? age_q[i] : age_q[i] + 1'b1;
            starved_d[i] = age_d[i] >= AGE_W'(STARVE_LIMIT);
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            owner_q    <= '0;
            grant_q    <= '0;
            issue_op_q <= '0;
            rr_ptr_q   <= '0;
            err_q      <= 1'b0;
            wd_q       <= '0;
            age_q      <= '{default: '0};
            starved_q  <= '0;
        end else begin
            owner_q    <= owner_d;
            grant_q    <= grant_d;
            issue_op_q <= issue_op_d;
            rr_ptr_q   <= rr_ptr_d;
            err_q      <= err_d;
            wd_q       <= wd_d;
            age_q      <= age_d;
            starved_q  <= starved_d;
        end

    assign grant       = grant_q;
    assign grant_id    = owner_q;
    assign issue_op    = issue_op_q;
    assign starved     = starved_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// tb_snoop_bus_arbiter: directed and randomized checks of snoop_bus_arbiter against a cycle reference model.
module tb_snoop_bus_arbiter;

    localparam int N   = 4;
    localparam int LIM = 16;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req;
    logic [11:0] req_op;
    logic        issue_ready, txn_done;
    logic [3:0]  grant;
    logic [1:0]  grant_id;
    logic        issue_valid;
    logic [2:0]  issue_op;
    logic        busy;
    logic [3:0]  starved;
    logic        err_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: phase 0 idle, 1 issue, 2 busy, 3 release
    int         m_phase, m_owner, m_ptr, m_wd;
    int         m_age [N];
    logic [2:0] m_op;
    bit         m_err;

    logic [3:0] keep;
    bit         rand_en, rand_bus;
    logic       rdy_val;
    int         done_lat;

    always #5 clk = ~clk;

    snoop_bus_arbiter #(.NUM_CPUS(N), .STARVE_LIMIT(LIM), .TIMEOUT(TMO), .AGE_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_op      (req_op),
        .grant       (grant),
        .grant_id    (grant_id),
        .issue_valid (issue_valid),
        .issue_op    (issue_op),
        .issue_ready (issue_ready),
        .txn_done    (txn_done),
        .busy        (busy),
        .starved     (starved),
        .err_timeout (err_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_owner = 0; m_ptr = 0; m_wd = 0; m_op = 3'b000; m_err = 1'b0;
        for (int i = 0; i < N; i++) m_age[i] = 0;
    endtask

    function automatic int pick();
        logic [3:0] cls;
        cls = 4'b0000;
        for (int i = 0; i < N; i++) if (req[i] && m_age[i] >= LIM) cls[i] = 1'b1;
        if (cls == 4'b0000)
            for (int i = 0; i < N; i++) if (req[i] && req_op[3*i +: 3] == 3'b000) cls[i] = 1'b1;
        if (cls == 4'b0000) cls = req;
        for (int k = 0; k < N; k++) if (cls[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic model_step();
        int w;
        w = (m_phase == 0) ? pick() : -1;
        for (int i = 0; i < N; i++)
            if (!req[i] || (m_phase == 0 ? i == w : i == m_owner)) m_age[i] = 0;
            else if (m_age[i] < 255) m_age[i]++;
        if (m_phase == 0) begin
            if (w >= 0) begin m_owner = w; m_op = req_op[3*w +: 3]; m_phase = 1; end
        end else if (m_phase == 1) begin
            if (issue_ready) begin m_phase = 2; m_wd = 0; end
            else if (!req[m_owner]) m_phase = 3;
        end else if (m_phase == 2) begin
            if (txn_done) m_phase = 3;
            else if (m_wd + 1 == TMO) begin m_err = 1'b1; m_phase = 3; end
            else m_wd++;
        end else begin
            m_ptr = (m_owner + 1) % N;
            m_phase = 0;
        end
    endtask

    task automatic check_all();
        logic [3:0] eg, es;
        eg = (m_phase != 0) ? 4'(1 << m_owner) : 4'b0000;
        for (int i = 0; i < N; i++) es[i] = (m_age[i] >= LIM);
        chk("grant", grant, eg);
        chk("grant_id", grant_id, m_owner);
        chk("issue_valid", issue_valid, m_phase == 1);
        chk("issue_op", issue_op, m_op);
        chk("busy", busy, m_phase != 0);
        chk("starved", starved, es);
        chk("err_timeout", err_timeout, m_err);
    endtask

    task automatic drive();
        bit own;
        issue_ready = rand_bus ? 1'($urandom_range(0, 1)) : rdy_val;
        txn_done = rand_bus ? ((m_phase == 2) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0))
                            : (m_phase == 2 && done_lat != 0 && m_wd + 1 == done_lat);
        for (int i = 0; i < N; i++) begin
            own = (m_phase != 0 && m_owner == i);
            if (own && m_phase >= 2) begin
                req[i] = keep[i] || (rand_en && $urandom_range(0, 1) == 1);
                if (rand_en) req_op[3*i +: 3] = 3'($urandom_range(0, 3));
            end else if (own) begin
                if (rand_en && !issue_ready && $urandom_range(0, 7) == 0) req[i] = 1'b0;
                if (rand_en) req_op[3*i +: 3] = 3'($urandom_range(0, 3));
            end else if (!req[i] && (keep[i] || (rand_en && $urandom_range(0, 3) == 0))) begin
                req[i] = 1'b1;
                if (rand_en) req_op[3*i +: 3] = 3'($urandom_range(0, 3));
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
        drive();
    endtask

    task automatic do_reset();
        @(posedge clk);
        model_step();
        #2;
        rst_n = 1'b0;
        req = 4'b0000; keep = 4'b0000; issue_ready = 1'b0; txn_done = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(input logic [3:0] g, input int lim, input string tag);
        for (int k = 0; k < lim && grant !== g; k++) cyc();
        chk(tag, grant, g);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        req = 4'b0000; req_op = '0; issue_ready = 1'b0; txn_done = 1'b0;
        keep = 4'b0000; rand_en = 0; rand_bus = 0; rdy_val = 1'b1; done_lat = 2;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // single requester, then pointer resumes after the previous owner
        req_op[8:6] = 3'b001; req[2] = 1'b1; rdy_val = 1'b0;
        cyc();
        chk("d1_grant", grant, 4'b0100);
        chk("d1_op", issue_op, 3'b001);
        cyc();
        rdy_val = 1'b1; issue_ready = 1'b1;
        wait_grant(4'b0000, 12, "d1_release");
        req_op[2:0] = 3'b001; req_op[11:9] = 3'b001; req[0] = 1'b1; req[3] = 1'b1;
        cyc();
        chk("d1_rr_ptr3", grant, 4'b1000);
        wait_grant(4'b0001, 12, "d1_next");

        // four continuous readers rotate fairly
        do_reset();
        keep = 4'b1111; req_op = 12'b001_001_001_001; req = 4'b1111; done_lat = 2;
        for (int k = 0; k < 5; k++) wait_grant(4'(1 << (k % N)), 12, "d2_order");
        chk("d2_no_starve", starved, 4'b0000);

        // writeback beats a read at the same pointer
        do_reset();
        req_op[2:0] = 3'b001; req_op[11:9] = 3'b000; req = 4'b1001;
        cyc();
        chk("d3_wb_first", grant, 4'b1000);
        wait_grant(4'b0001, 12, "d3_read_next");

        // reader held off by writebacks becomes urgent
        do_reset();
        keep = 4'b0101; req_op = 12'b000_000_001_000; req = 4'b0111;
        for (int k = 0; k < 40 && !starved[1]; k++) cyc();
        chk("d4_starved", starved[1], 1'b1);
        wait_grant(4'b0010, 12, "d4_urgent_grant");

        // done on the timeout cycle wins; withheld done trips the watchdog
        do_reset();
        done_lat = TMO; req_op[5:3] = 3'b010; req[1] = 1'b1;
        cyc();
        wait_grant(4'b0000, 30, "d5_tie_release");
        chk("d5_tie_no_err", err_timeout, 1'b0);
        done_lat = 0; req[2] = 1'b1;
        for (int k = 0; k < 30 && !err_timeout; k++) cyc();
        chk("d5_err", err_timeout, 1'b1);
        cyc();
        chk("d5_released", grant, 4'b0000);
        done_lat = 2; req[0] = 1'b1;
        cyc();
        chk("d5_regrant", grant, 4'b0001);
        wait_grant(4'b0000, 12, "d5_done");
        chk("d5_sticky", err_timeout, 1'b1);

        // cancel during issue, then reset while busy
        do_reset();
        chk("d6_err_cleared", err_timeout, 1'b0);
        rdy_val = 1'b0; req_op[5:3] = 3'b001; req[1] = 1'b1;
        cyc();
        chk("d6_grant", grant, 4'b0010);
        req[1] = 1'b0;
        cyc();
        chk("d6_cancel_no_issue", issue_valid, 1'b0);
        cyc();
        chk("d6_cancel_idle", grant, 4'b0000);
        rdy_val = 1'b1; done_lat = 0; req[3] = 1'b1;
        cyc();
        cyc();
        chk("d6_busy", busy, 1'b1);
        do_reset();
        chk("d6_rst_grant", grant, 4'b0000);

        // randomized traffic with periodic resets
        for (int r = 0; r < 5; r++) begin
            rand_en = 1; rand_bus = 1;
            repeat (700) cyc();
            rand_en = 0; rand_bus = 0;
            do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
